// File: rtl/c_loop_mem_ctrl.sv
// Sequencer for the c_loop_w_memory datapath: sum += mem[i] for i in 0..LOOP_N-1.
// Optional LOOP_WRITEBACK_EN adds a WRITE state storing the running sum back to mem[i].
module c_loop_mem_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned LOOP_N = 10,
    parameter int unsigned SUM_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wrdata,
    input  logic [DATA_W-1:0] mem_rddata,
    output logic [SUM_W-1:0]  sum,
    output logic [ADDR_W:0]   loop_i
);

    localparam logic [ADDR_W:0] LAST_I = (ADDR_W+1)'(LOOP_N - 1);
    localparam logic [ADDR_W:0] ONE_I  = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_ACC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state, state_d;
    logic [SUM_W-1:0]  sum_d, acc_sum;
    logic [ADDR_W:0]   loop_i_d;
    logic [ADDR_W-1:0] addr_d;
    logic              rden_d, wren_d, done_d, busy_d, advance;
    logic [DATA_W-1:0] wrdata_d, rd_q, rd_q_d;

    // Next state and next registered outputs.
    always_comb begin
        state_d  = state;
        sum_d    = sum;
        loop_i_d = loop_i;
        addr_d   = mem_addr;
        rden_d   = 1'b0;
        wren_d   = 1'b0;
        wrdata_d = '0;
        done_d   = 1'b0;
        busy_d   = 1'b0;
        rd_q_d   = rd_q;
        advance  = 1'b0;
        acc_sum  = sum + SUM_W'($signed(rd_q));

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_READ;
                    sum_d    = '0;
                    loop_i_d = '0;
                    addr_d   = '0;
                    rden_d   = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
                busy_d  = 1'b1;
            end
            S_WAIT: begin
                rd_q_d  = mem_rddata;
                state_d = S_ACC;
                busy_d  = 1'b1;
            end
            S_ACC: begin
                sum_d = acc_sum;
`ifdef LOOP_WRITEBACK_EN
                state_d  = S_WRITE;
                wren_d   = 1'b1;
                wrdata_d = DATA_W'(acc_sum);
                busy_d   = 1'b1;
`else
                advance = 1'b1;
`endif
            end
`ifdef LOOP_WRITEBACK_EN
            S_WRITE: advance = 1'b1;
`endif
            S_DONE: begin
                if (start) begin
                    done_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // End-of-iteration decision shared by ACC and WRITE.
        if (advance) begin
            if (loop_i == LAST_I) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                loop_i_d = loop_i + ONE_I;
                addr_d   = ADDR_W'(loop_i_d);
                state_d  = S_READ;
                rden_d   = 1'b1;
                busy_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            sum        <= '0;
            loop_i     <= '0;
            mem_addr   <= '0;
            mem_rden   <= 1'b0;
            mem_wren   <= 1'b0;
            mem_wrdata <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            rd_q       <= '0;
        end else begin
            state      <= state_d;
            sum        <= sum_d;
            loop_i     <= loop_i_d;
            mem_addr   <= addr_d;
            mem_rden   <= rden_d;
            mem_wren   <= wren_d;
            mem_wrdata <= wrdata_d;
            done       <= done_d;
            busy       <= busy_d;
            rd_q       <= rd_q_d;
        end
    end

endmodule

// File: tb/tb_c_loop_mem_ctrl.sv
// Directed bench for c_loop_mem_ctrl: default instance (LOOP_N=10) plus a
// LOOP_N=16/SUM_W=8 instance for the wrap case; honours LOOP_WRITEBACK_EN.
module tb_c_loop_mem_ctrl;

`ifdef LOOP_WRITEBACK_EN
    localparam int CPI = 4;
`else
    localparam int CPI = 3;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults
    logic        rst_a, start_a, done_a, busy_a, rden_a, wren_a;
    logic [3:0]  addr_a;
    logic [7:0]  wrdata_a, rddata_a;
    logic [11:0] sum_a;
    logic [4:0]  loop_i_a;

    // Instance B: LOOP_N=16, SUM_W=8
    logic        rst_b, start_b, done_b, busy_b, rden_b, wren_b;
    logic [3:0]  addr_b;
    logic [7:0]  wrdata_b, rddata_b;
    logic [7:0]  sum_b;
    logic [4:0]  loop_i_b;

    c_loop_mem_ctrl dut (
        .clk(clk), .rst(rst_a), .start(start_a), .done(done_a), .busy(busy_a),
        .mem_addr(addr_a), .mem_rden(rden_a), .mem_wren(wren_a),
        .mem_wrdata(wrdata_a), .mem_rddata(rddata_a), .sum(sum_a), .loop_i(loop_i_a)
    );

    c_loop_mem_ctrl #(.LOOP_N(16), .SUM_W(8)) dut16 (
        .clk(clk), .rst(rst_b), .start(start_b), .done(done_b), .busy(busy_b),
        .mem_addr(addr_b), .mem_rden(rden_b), .mem_wren(wren_b),
        .mem_wrdata(wrdata_b), .mem_rddata(rddata_b), .sum(sum_b), .loop_i(loop_i_b)
    );

    // RAM models with a bench-controlled bulk load port
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [7:0] ld_a  [16];
    logic [7:0] ld_b  [16];
    logic       ld_en_a = 1'b0, ld_en_b = 1'b0;
    int         rden_cnt_a = 0, wren_cnt_a = 0, viol = 0;

    always @(posedge clk) begin
        if (rden_a) rddata_a <= mem_a[addr_a];
        if (ld_en_a) begin
            for (int i = 0; i < 16; i++) mem_a[i] <= ld_a[i];
        end else if (wren_a) begin
            mem_a[addr_a] <= wrdata_a;
        end
        if (rden_b) rddata_b <= mem_b[addr_b];
        if (ld_en_b) begin
            for (int i = 0; i < 16; i++) mem_b[i] <= ld_b[i];
        end else if (wren_b) begin
            mem_b[addr_b] <= wrdata_b;
        end
        if (rden_a) rden_cnt_a <= rden_cnt_a + 1;
        if (wren_a) wren_cnt_a <= wren_cnt_a + 1;
        if ((rden_a && wren_a) || (rden_b && wren_b)) viol <= viol + 1;
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // mode 0: mem[i]=i+1, mode 1: all 8'hFF
    task automatic load_a(input int mode);
        for (int i = 0; i < 16; i++) ld_a[i] = (mode == 0) ? 8'(i + 1) : 8'hFF;
        ld_en_a = 1'b1;
        @(posedge clk); #1;
        ld_en_a = 1'b0;
    endtask

    // Raise start; edges = edge index (start-sampling edge = 0) where done is first seen.
    task automatic run_a(output int edges, output logic [31:0] first);
        int n;
        n = -1;
        edges = -1;
        first = '1;
        start_a = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            n++;
            if (n == 0) first = 32'({busy_a, rden_a, addr_a});
            if (done_a) begin
                edges = n;
                break;
            end
        end
    endtask

    int          edges, c0, n;
    logic [31:0] first;

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum",    32'(sum_a), 32'h0);
        check("rst_loop_i", 32'(loop_i_a), 32'h0);
        check("rst_ctl",    32'({done_a, busy_a, rden_a, wren_a, addr_a, wrdata_a}), 32'h0);
        rst_a = 1'b1; rst_b = 1'b1;

        // Test 1: mem=1..10
        load_a(0);
        c0 = wren_cnt_a;
        run_a(edges, first);
        check("t1_first",  first, 32'h30);
        check("t1_lat",    32'(edges), 32'(CPI * 10));
        check("t1_sum",    32'(sum_a), 32'h037);
        check("t1_loop_i", 32'(loop_i_a), 32'd9);
        check("t1_busy",   32'(busy_a), 32'd0);
`ifdef LOOP_WRITEBACK_EN
        check("t1_wren",   32'(wren_cnt_a - c0), 32'd10);
        for (int i = 0; i < 10; i++)
            check("t6_mem", 32'(mem_a[i]), 32'((i + 1) * (i + 2) / 2));
`else
        check("t1_wren",   32'(wren_cnt_a - c0), 32'd0);
`endif
        start_a = 1'b0;
        @(posedge clk); #1;
        check("t1_done_drop", 32'(done_a), 32'd0);

        // Test 2: all 8'hFF gives -10
        load_a(1);
        run_a(edges, first);
        check("t2_lat", 32'(edges), 32'(CPI * 10));
        check("t2_sum", 32'(sum_a), 32'hFF6);
        start_a = 1'b0;
        @(posedge clk); #1;

        // Test 4: reset at the edge after the 4th READ
        load_a(0);
        start_a = 1'b1;
        n = -1;
        while (n < CPI * 3) begin
            @(posedge clk); #1;
            n++;
        end
        check("t4_read4", 32'({rden_a, addr_a}), 32'h13);
        rst_a = 1'b0;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("t4_sum",  32'(sum_a), 32'h0);
        check("t4_ctl",  32'({done_a, busy_a, rden_a, wren_a}), 32'h0);
        check("t4_loop", 32'(loop_i_a), 32'h0);
        rst_a = 1'b1;
        c0 = rden_cnt_a + wren_cnt_a;
        repeat (5) @(posedge clk);
        #1;
        check("t4_quiet", 32'(rden_cnt_a + wren_cnt_a - c0), 32'd0);
        load_a(0);
        run_a(edges, first);
        check("t4_rerun_lat", 32'(edges), 32'(CPI * 10));
        check("t4_rerun_sum", 32'(sum_a), 32'h037);

        // Test 5: start held through DONE does not retrigger
        c0 = rden_cnt_a;
        repeat (10) @(posedge clk);
        #1;
        check("t5_done_held", 32'(done_a), 32'd1);
        check("t5_no_read",   32'(rden_cnt_a - c0), 32'd0);
        check("t5_loop_i",    32'(loop_i_a), 32'd9);
        start_a = 1'b0;
        @(posedge clk); #1;
        check("t5_idle", 32'({done_a, busy_a}), 32'h0);
        load_a(0);
        run_a(edges, first);
        check("t5_rerun_sum", 32'(sum_a), 32'h037);
        start_a = 1'b0;

        // Test 3: LOOP_N=16, SUM_W=8, all 8'h7F wraps to 8'hF0
        for (int i = 0; i < 16; i++) ld_b[i] = 8'h7F;
        ld_en_b = 1'b1;
        @(posedge clk); #1;
        ld_en_b = 1'b0;
        start_b = 1'b1;
        edges = -1;
        n = -1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            n++;
            if (done_b) begin
                edges = n;
                break;
            end
        end
        check("t3_lat",    32'(edges), 32'(CPI * 16));
        check("t3_sum",    32'(sum_b), 32'hF0);
        check("t3_loop_i", 32'(loop_i_b), 32'd15);
        start_b = 1'b0;
        @(posedge clk); #1;

        check("rd_wr_excl", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
